// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, memory and status signals of the two-port memory-bus arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_done;
  logic              i_err;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output i_done, i_err, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_done, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  i_done, i_err, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_done, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D cache to main-memory arbiter with watchdog; ARB_RR_EN selects round-robin
// All outputs are registered; one transaction in flight (IDLE -> BUSY -> RESP).
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              owner_d, owner_d_n;
  logic              any_req, grant_d, timeout_hit, finish;

  logic              mem_req_n, mem_we_n, busy_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              i_done_n, i_err_n, d_done_n, d_err_n;
  logic [DATA_W-1:0] i_rdata_n, d_rdata_n, resp_rdata;
  logic              resp_err;

  assign any_req = bus.i_req | bus.d_req;

`ifdef ARB_RR_EN
  // last_d == 1 means the data side won the previous grant.
  logic last_d;
  assign grant_d = bus.d_req && (!bus.i_req || !last_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_d <= 1'b0;
    else if (state == S_IDLE && any_req)
      last_d <= grant_d;
  end
`else
  assign grant_d = bus.d_req;
`endif

  // cnt counts completed wait cycles; the Nth silent BUSY cycle ends the transaction.
  assign timeout_hit = (cnt >= CNT_LAST);
  assign finish      = (state == S_BUSY) && (bus.mem_ready || timeout_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (any_req) state_n = S_BUSY;
      S_BUSY:  if (finish)  state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we_n    = bus.mem_we;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    owner_d_n   = owner_d;
    cnt_n       = cnt;
    mem_req_n   = (state_n == S_BUSY);
    busy_n      = (state_n != S_IDLE);
    i_done_n    = 1'b0;
    i_err_n     = 1'b0;
    i_rdata_n   = '0;
    d_done_n    = 1'b0;
    d_err_n     = 1'b0;
    d_rdata_n   = '0;
    // mem_ready beats a coincident timeout; writes return zero data.
    resp_rdata  = (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : '0;
    resp_err    = !bus.mem_ready;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          owner_d_n   = grant_d;
          mem_we_n    = grant_d ? bus.d_we    : bus.i_we;
          mem_addr_n  = grant_d ? bus.d_addr  : bus.i_addr;
          mem_wdata_n = grant_d ? bus.d_wdata : bus.i_wdata;
          cnt_n       = '0;
        end
      end
      S_BUSY: begin
        if (!bus.mem_ready && cnt != CNT_MAX)
          cnt_n = cnt + CW'(1);
        if (finish) begin
          mem_we_n    = 1'b0;
          mem_addr_n  = '0;
          mem_wdata_n = '0;
          if (owner_d) begin
            d_done_n  = 1'b1;
            d_err_n   = resp_err;
            d_rdata_n = resp_rdata;
          end else begin
            i_done_n  = 1'b1;
            i_err_n   = resp_err;
            i_rdata_n = resp_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      owner_d       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.i_done    <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_done    <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      cnt           <= cnt_n;
      owner_d       <= owner_d_n;
      bus.mem_req   <= mem_req_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
      bus.busy      <= busy_n;
      bus.i_done    <= i_done_n;
      bus.i_err     <= i_err_n;
      bus.i_rdata   <= i_rdata_n;
      bus.d_done    <= d_done_n;
      bus.d_err     <= d_err_n;
      bus.d_rdata   <= d_rdata_n;
    end
  end
endmodule
